// File: rtl/vga_pkg.sv
// Timing constants and helpers shared by the raster-scan generator.
package vga_pkg;

    // Default 640x480@60 timing, in pixel clocks / lines
    localparam int unsigned H_VISIVEL_PADRAO = 640;
    localparam int unsigned H_FRENTE_PADRAO  = 16;
    localparam int unsigned H_SYNC_PADRAO    = 96;
    localparam int unsigned H_TRAS_PADRAO    = 48;
    localparam int unsigned V_VISIVEL_PADRAO = 480;
    localparam int unsigned V_FRENTE_PADRAO  = 10;
    localparam int unsigned V_SYNC_PADRAO    = 2;
    localparam int unsigned V_TRAS_PADRAO    = 33;

    // Full period of one axis from its four segments
    function automatic int unsigned total_eixo(input int unsigned visivel,
                                               input int unsigned frente,
                                               input int unsigned sync,
                                               input int unsigned tras);
        return visivel + frente + sync + tras;
    endfunction

    // Smallest counter width able to hold total-1
    function automatic int unsigned largura_minima(input int unsigned total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/gerador_varredura_contador_eixo.sv
// One wrapping axis counter with registered sync flag and next-value visibility flag.
module contador_eixo
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL       = 800,
    parameter int unsigned VISIVEL     = 640,
    parameter int unsigned INICIO_SYNC = 656,
    parameter int unsigned FIM_SYNC    = 752,
    parameter int unsigned SYNC_ATIVO  = 0,
    parameter int unsigned LARGURA     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               avanca,
    output logic [LARGURA-1:0] valor,
    output logic               visivel_eixo, // visibility of the value after this edge
    output logic               sync,
    output logic               ultimo
);

    if (LARGURA < largura_minima(TOTAL)) begin : g_largura_invalida
        $error("contador_eixo: LARGURA too small for TOTAL");
    end

    localparam logic [LARGURA:0] ULTIMO_V  = (LARGURA+1)'(TOTAL - 1);
    localparam logic [LARGURA:0] VISIVEL_V = (LARGURA+1)'(VISIVEL);
    localparam logic [LARGURA:0] INICIO_V  = (LARGURA+1)'(INICIO_SYNC);
    localparam logic [LARGURA:0] FIM_V     = (LARGURA+1)'(FIM_SYNC);
    localparam logic             ATIVO     = (SYNC_ATIVO != 0);

    logic [LARGURA-1:0] prox;
    logic [LARGURA:0]   prox_ext;
    logic               sync_prox;

    assign ultimo = ({1'b0, valor} == ULTIMO_V);

    // Next counter value and the flags derived from it, so registered flags never lag the count
    always_comb begin
        prox = valor;
        if (avanca) begin
            prox = ultimo ? '0 : valor + LARGURA'(1);
        end
        prox_ext     = {1'b0, prox};
        visivel_eixo = (prox_ext < VISIVEL_V);
        sync_prox    = ((prox_ext >= INICIO_V) && (prox_ext < FIM_V)) ? ATIVO : ~ATIVO;
    end

    // Counter and sync registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valor <= '0;
            sync  <= ~ATIVO;
        end else begin
            valor <= prox;
            sync  <= sync_prox;
        end
    end

endmodule

// File: rtl/gerador_varredura.sv
// Raster-scan timing generator: column/line counters with registered sync and visible flags.
module gerador_varredura
    import vga_pkg::*;
#(
    parameter int unsigned LARGURA    = 10,
    parameter int unsigned H_VISIVEL  = H_VISIVEL_PADRAO,
    parameter int unsigned H_FRENTE   = H_FRENTE_PADRAO,
    parameter int unsigned H_SYNC     = H_SYNC_PADRAO,
    parameter int unsigned H_TRAS     = H_TRAS_PADRAO,
    parameter int unsigned V_VISIVEL  = V_VISIVEL_PADRAO,
    parameter int unsigned V_FRENTE   = V_FRENTE_PADRAO,
    parameter int unsigned V_SYNC     = V_SYNC_PADRAO,
    parameter int unsigned V_TRAS     = V_TRAS_PADRAO,
    parameter int unsigned SYNC_ATIVO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [LARGURA-1:0] x,
    output logic [LARGURA-1:0] y,
    output logic               visivel,
    output logic               hsync,
    output logic               vsync,
    output logic               fim_linha,
    output logic               fim_quadro
);

    localparam int unsigned H_TOTAL = total_eixo(H_VISIVEL, H_FRENTE, H_SYNC, H_TRAS);
    localparam int unsigned V_TOTAL = total_eixo(V_VISIVEL, V_FRENTE, V_SYNC, V_TRAS);

    logic h_ultimo, v_ultimo;
    logic h_vis_prox, v_vis_prox;
    logic avanca_v;

    // Lines advance only on the enabled last column
    assign avanca_v = en & h_ultimo;

    contador_eixo #(
        .TOTAL       (H_TOTAL),
        .VISIVEL     (H_VISIVEL),
        .INICIO_SYNC (H_VISIVEL + H_FRENTE),
        .FIM_SYNC    (H_VISIVEL + H_FRENTE + H_SYNC),
        .SYNC_ATIVO  (SYNC_ATIVO),
        .LARGURA     (LARGURA)
    ) u_horizontal (
        .clk          (clk),
        .rst          (rst),
        .avanca       (en),
        .valor        (x),
        .visivel_eixo (h_vis_prox),
        .sync         (hsync),
        .ultimo       (h_ultimo)
    );

    contador_eixo #(
        .TOTAL       (V_TOTAL),
        .VISIVEL     (V_VISIVEL),
        .INICIO_SYNC (V_VISIVEL + V_FRENTE),
        .FIM_SYNC    (V_VISIVEL + V_FRENTE + V_SYNC),
        .SYNC_ATIVO  (SYNC_ATIVO),
        .LARGURA     (LARGURA)
    ) u_vertical (
        .clk          (clk),
        .rst          (rst),
        .avanca       (avanca_v),
        .valor        (y),
        .visivel_eixo (v_vis_prox),
        .sync         (vsync),
        .ultimo       (v_ultimo)
    );

    // Visible area flag registered from both axes' next values; (0,0) is visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            visivel <= 1'b1;
        end else begin
            visivel <= h_vis_prox & v_vis_prox;
        end
    end

    assign fim_linha  = en & h_ultimo;
    assign fim_quadro = fim_linha & v_ultimo;

endmodule

// File: tb/tb_gerador_varredura.sv
// Randomised bench: three configurations checked against a pixel-index reference model.
module tb_gerador_varredura;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    // Default 640x480 timing
    logic [9:0] d_x, d_y;
    logic d_vis, d_hs, d_vs, d_fl, d_fq;
    // Default horizontal, short vertical (frame fits the run)
    logic [9:0] m_x, m_y;
    logic m_vis, m_hs, m_vs, m_fl, m_fq;
    // Tiny timing, active-high sync
    logic [2:0] p_x, p_y;
    logic p_vis, p_hs, p_vs, p_fl, p_fq;

    gerador_varredura u_dut_padrao (
        .clk (clk), .rst (rst), .en (en), .x (d_x), .y (d_y), .visivel (d_vis),
        .hsync (d_hs), .vsync (d_vs), .fim_linha (d_fl), .fim_quadro (d_fq)
    );

    gerador_varredura #(
        .LARGURA (10), .V_VISIVEL (4), .V_FRENTE (1), .V_SYNC (2), .V_TRAS (1)
    ) u_dut_medio (
        .clk (clk), .rst (rst), .en (en), .x (m_x), .y (m_y), .visivel (m_vis),
        .hsync (m_hs), .vsync (m_vs), .fim_linha (m_fl), .fim_quadro (m_fq)
    );

    gerador_varredura #(
        .LARGURA (3), .H_VISIVEL (4), .H_FRENTE (1), .H_SYNC (2), .H_TRAS (1),
        .V_VISIVEL (3), .V_FRENTE (1), .V_SYNC (1), .V_TRAS (1), .SYNC_ATIVO (1)
    ) u_dut_pequeno (
        .clk (clk), .rst (rst), .en (en), .x (p_x), .y (p_y), .visivel (p_vis),
        .hsync (p_hs), .vsync (p_vs), .fim_linha (p_fl), .fim_quadro (p_fq)
    );

    localparam int unsigned FR_D = 800 * 525;
    localparam int unsigned FR_M = 800 * 8;
    localparam int unsigned FR_P = 8 * 6;

    int unsigned checks = 0;
    int unsigned erros  = 0;
    // Model: number of enabled edges since reset, modulo the frame length
    int unsigned n_d = 0, n_m = 0, n_p = 0;
    int unsigned fq_obs = 0, fq_esp = 0;

    task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic verifica(input string nome, input int unsigned n,
                            input int unsigned hv, input int unsigned hf, input int unsigned hs,
                            input int unsigned ht, input int unsigned vv, input int unsigned vf,
                            input int unsigned vs, input int unsigned vt, input bit ativo,
                            input logic [31:0] ox, input logic [31:0] oy, input logic ovis,
                            input logic ohs, input logic ovs, input logic ofl, input logic ofq);
        int unsigned ex, ey;
        bit hact, vact, efl, efq;
        ex   = n % ht;
        ey   = n / ht;
        hact = (ex >= hv + hf) && (ex < hv + hf + hs);
        vact = (ey >= vv + vf) && (ey < vv + vf + vs);
        efl  = (en === 1'b1) && (ex == ht - 1);
        efq  = efl && (ey == vt - 1);
        checa({nome, ".x"}, ox, ex);
        checa({nome, ".y"}, oy, ey);
        checa({nome, ".visivel"}, 32'(ovis), 32'((ex < hv) && (ey < vv)));
        checa({nome, ".hsync"}, 32'(ohs), 32'(hact ? ativo : !ativo));
        checa({nome, ".vsync"}, 32'(ovs), 32'(vact ? ativo : !ativo));
        checa({nome, ".fim_linha"}, 32'(ofl), 32'(efl));
        checa({nome, ".fim_quadro"}, 32'(ofq), 32'(efq));
    endtask

    task automatic verifica_todos();
        verifica("padrao", n_d, 640, 16, 96, 800, 480, 10, 2, 525, 1'b0,
                 32'(d_x), 32'(d_y), d_vis, d_hs, d_vs, d_fl, d_fq);
        verifica("medio", n_m, 640, 16, 96, 800, 4, 1, 2, 8, 1'b0,
                 32'(m_x), 32'(m_y), m_vis, m_hs, m_vs, m_fl, m_fq);
        verifica("pequeno", n_p, 4, 1, 2, 8, 3, 1, 1, 6, 1'b1,
                 32'(p_x), 32'(p_y), p_vis, p_hs, p_vs, p_fl, p_fq);
        if (p_fq === 1'b1) fq_obs++;
        if (en === 1'b1 && n_p == FR_P - 1) fq_esp++;
    endtask

    // One clock: advance the model as the DUT should, drive the next en, then compare
    task automatic passo(input logic prox_en);
        @(posedge clk);
        if (rst) begin
            n_d = 0; n_m = 0; n_p = 0;
        end else if (en) begin
            n_d = (n_d + 1) % FR_D;
            n_m = (n_m + 1) % FR_M;
            n_p = (n_p + 1) % FR_P;
        end
        #1;
        en = prox_en;
        #1;
        verifica_todos();
    endtask

    initial begin
        // Reset state, including rst winning over en
        for (int i = 0; i < 3; i++) passo(1'b0);
        passo(1'b1);
        passo(1'b1);
        #2 rst = 1'b0;

        // One full default line plus a little, continuously enabled
        for (int i = 0; i < 810; i++) passo(1'b1);

        // en pattern 1,0,0,1
        for (int i = 0; i < 200; i++) passo((i % 4 == 0) || (i % 4 == 3));

        // Random enables until the default column sits at 700 (hsync active)
        for (int i = 0; i < 5000; i++) begin
            if (n_d % 800 == 700) break;
            passo(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        checa("alcance_x700", n_d % 800, 700);

        // Asynchronous reset mid-cycle: outputs must clear before the next edge
        #2 rst = 1'b1;
        #1;
        n_d = 0; n_m = 0; n_p = 0;
        verifica_todos();
        passo(1'b1);
        #2 rst = 1'b0;
        passo(1'b1);
        checa("retomada_x", 32'(d_x), 1);

        // Long random run: several small frames and a complete medium frame
        fq_obs = 0;
        fq_esp = 0;
        for (int i = 0; i < 9000; i++) passo(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
        checa("contagem_fim_quadro", fq_obs, fq_esp);

        $display("Simulation finished: %0d checks, %0d errors", checks, erros);
        $finish;
    end

endmodule

// File: doc/gerador_varredura.md
# gerador_varredura

Parametrised raster-scan timing generator: two wrapping counters (column x, line y) plus registered sync and visible-area flags for a VGA-class display. It is the sequential successor of the fixed "x ≤ 640" bound comparison. Every horizontal and vertical boundary is a parameter, and the comparisons run against live counters instead of a static input. It sits between the pixel-clock enable and the pixel/character renderers, which consume x, y and visivel.

## Interface
Parameters:
- LARGURA, 10, width of x and y; must hold H_TOTAL-1 and V_TOTAL-1, otherwise elaboration error
- H_VISIVEL, 640, visible columns
- H_FRENTE, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_TRAS, 48, horizontal back porch
- V_VISIVEL, 480, visible lines
- V_FRENTE, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_TRAS, 33, vertical back porch
- SYNC_ATIVO, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- en  input  1  pixel tick; counters advance only on cycles with en=1
- x  output  LARGURA  current column
- y  output  LARGURA  current line
- visivel  output  1  1 when x < H_VISIVEL and y < V_VISIVEL
- hsync  output  1  horizontal sync, level set by SYNC_ATIVO
- vsync  output  1  vertical sync, level set by SYNC_ATIVO
- fim_linha  output  1  one-cycle strobe, last column being consumed
- fim_quadro  output  1  one-cycle strobe, last pixel of frame being consumed

## Operation
- Derived totals: H_TOTAL = sum of the four H parameters (default 800); V_TOTAL = sum of the four V parameters (default 525).
- Reset (async assert, synchronous-safe release): x=0, y=0, visivel=1, hsync=vsync=!SYNC_ATIVO, fim_linha=fim_quadro=0.
- On clk rising edge with en=1:
  - x increments.
  - When x = H_TOTAL-1, x wraps to 0 and y increments.
  - When y = V_TOTAL-1 at the same time, y wraps to 0.
- en=0: x, y and all registered flags hold. Strobes are 0.
- visivel, hsync and vsync are registers. They are computed from the next counter values, so on every cycle they describe the current x,y exactly, with no skew.
- hsync is active iff H_VISIVEL+H_FRENTE ≤ x < H_VISIVEL+H_FRENTE+H_SYNC (default 656..751).
- vsync is active iff V_VISIVEL+V_FRENTE ≤ y < V_VISIVEL+V_FRENTE+V_SYNC (default 490..491). It depends on y only and is not column-gated.
- fim_linha = en AND (x = H_TOTAL-1). This is a combinational decode of registered x.
- fim_quadro = fim_linha AND (y = V_TOTAL-1).
- Comparisons are unsigned at LARGURA bits. No counter value ≥ H_TOTAL or V_TOTAL is ever reachable.

## Timing
- Latency from en edge to new x/y/flags: 1 clock.
- One full frame is H_TOTAL × V_TOTAL enabled cycles (default 420000).
- Reset mid-frame: all outputs return to reset values immediately and asynchronously. The first enabled edge after release produces x=1, y=0.
- en held high continuously: x advances every cycle. en toggling stretches the timing but never skips or repeats a count.
- rst and en both high: rst wins.

## Structure
- Shared package vga_pkg:
  - default timing constants for 640×480@60
  - function computing totals from four segment lengths
  - function for the minimum LARGURA
- One sub-module, contador_eixo, instantiated twice:
  - parameters: TOTAL, VISIVEL, INICIO_SYNC, FIM_SYNC, SYNC_ATIVO, LARGURA
  - inputs: clk, rst, avanca
  - outputs: valor, visivel_eixo, sync, ultimo
- Wiring between the two instances:
  - horizontal instance: avanca = en
  - vertical instance: avanca = en AND horizontal ultimo
- Top-level visivel is the registered AND of the two axis visible flags, computed from their next values.

## Test plan
- Reset then en=1 for 800 cycles → x runs 0..799 then returns to 0; y goes 0→1 on that wrap; fim_linha is high only in the cycle with x=799.
- Default parameters, hsync check → hsync=0 exactly for x=656..751 on every line; visivel=0 for x ≥ 640.
- Full frame of 420000 enabled cycles →
  - vsync low only for y=490..491
  - exactly one fim_quadro, at x=799, y=524
  - next cycle shows x=0, y=0, visivel=1
- en pattern 1,0,0,1 repeated → x advances only on en=1 cycles; flags and counters stable while en=0; strobes 0 while en=0.
- rst asserted asynchronously at x=700, y=300 (hsync active) → x=0, y=0 and hsync inactive before the next clk edge; counting resumes from 0 after release.
- Re-parameterised with H_VISIVEL=4, H_FRENTE=1, H_SYNC=2, H_TRAS=1, V parameters 3/1/1/1, SYNC_ATIVO=1, LARGURA=3 →
  - H_TOTAL=8 and V_TOTAL=6
  - hsync high only at x=5..6
  - vsync high only at y=4
  - fim_quadro every 48 enabled cycles
